rvh_l1d_ptw_req_sched: RTL and testbench

- Schedules page-table-walker (PTW) accesses onto the shared L1D load-pipe request port.
- The port is shared between fresh PTW walk requests, PTW replays from the PTW replay buffer, and ordinary LSU loads.
- Tracks the single outstanding walk from acceptance through response, forwards replays only while that walk is outstanding, and uses a starvation counter so LSU loads always make progress.

---
 rtl/rvh_l1d_pkg.sv | 19 +
 rtl/rvh_l1d_ptw_lsu_starve_arb.sv | 47 ++++
 rtl/rvh_l1d_ptw_req_sched.sv | 148 ++++++++++++++
 tb/tb_rvh_l1d_ptw_req_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared types and widths for the L1D PTW request scheduling slice.
package rvh_l1d_pkg;

    localparam int unsigned PTW_ID_WIDTH         = 4;
    localparam int unsigned PADDR_WIDTH          = 56;
    localparam int unsigned PTW_REPLAY_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } ptw_sched_state_e;

    typedef struct packed {
        logic [PTW_ID_WIDTH-1:0] id;
        logic [PADDR_WIDTH-1:0]  paddr;
    } ptw_req_buffer_t;

endpackage

// File: rtl/rvh_l1d_ptw_lsu_starve_arb.sv
// Two-way arbiter for a shared pipe port: a priority requester normally wins,
// but an LSU load that has lost STARVE_LIMIT consecutive cycles is force-granted.
module rvh_l1d_ptw_lsu_starve_arb #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic prio_vld_i,
    input  logic lsu_vld_i,
    input  logic port_rdy_i,
    output logic pipe_vld_o,
    output logic prio_sel_o,
    output logic lsu_rdy_o
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          force_lsu;

    assign force_lsu  = lsu_vld_i & (starve_cnt_q == LIMIT);
    assign prio_sel_o = prio_vld_i & ~force_lsu;
    assign pipe_vld_o = prio_vld_i | lsu_vld_i;
    assign lsu_rdy_o  = port_rdy_i & lsu_vld_i & ~prio_sel_o;

    // Count consecutive losing cycles of a pending LSU load; clear on grant or idle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lsu_vld_i || lsu_rdy_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/rvh_l1d_ptw_req_sched.sv
// Schedules a single outstanding PTW walk and its replays onto the shared
// L1D load-pipe port, sharing it fairly with LSU loads.
module rvh_l1d_ptw_req_sched
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned MAX_REPLAY   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ptw_walk_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
    output logic                    ptw_walk_req_rdy_o,
    input  logic                    replay_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] replay_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  replay_req_paddr_i,
    output logic                    replay_req_rdy_o,
    input  logic                    lsu_ld_req_vld_i,
    output logic                    lsu_ld_req_rdy_o,
    output logic                    pipe_req_vld_o,
    output logic                    pipe_req_is_ptw_o,
    output logic [PTW_ID_WIDTH-1:0] pipe_req_id_o,
    output logic [PADDR_WIDTH-1:0]  pipe_req_paddr_o,
    input  logic                    pipe_req_rdy_i,
    input  logic                    ptw_walk_resp_vld_i,
    input  logic                    ptw_walk_resp_rdy_i,
    output logic                    busy_o,
    output logic                    replay_overflow_o
);

    localparam logic [PTW_REPLAY_CNT_WIDTH-1:0] MAX_CNT = PTW_REPLAY_CNT_WIDTH'(MAX_REPLAY);

    ptw_sched_state_e                state_q, state_d;
    ptw_req_buffer_t                 req_buf_q, req_buf_d;
    logic [PTW_REPLAY_CNT_WIDTH-1:0] replay_cnt_q, replay_cnt_d;
    logic                            ovf_q, ovf_d;

    logic resp_hsk;
    logic ptw_side_vld;
    logic ptw_hsk;

    assign resp_hsk     = ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i & (state_q == WAIT_RESP);
    assign ptw_side_vld = (state_q == ISSUE) |
                          ((state_q == WAIT_RESP) & replay_req_vld_i & ~resp_hsk);

    rvh_l1d_ptw_lsu_starve_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .prio_vld_i (ptw_side_vld),
        .lsu_vld_i  (lsu_ld_req_vld_i),
        .port_rdy_i (pipe_req_rdy_i),
        .pipe_vld_o (pipe_req_vld_o),
        .prio_sel_o (pipe_req_is_ptw_o),
        .lsu_rdy_o  (lsu_ld_req_rdy_o)
    );

    assign ptw_hsk            = pipe_req_is_ptw_o & pipe_req_rdy_i;
    assign replay_req_rdy_o   = ptw_hsk & (state_q == WAIT_RESP);
    assign ptw_walk_req_rdy_o = (state_q == IDLE);
    assign busy_o             = (state_q != IDLE);
    assign replay_overflow_o  = ovf_q;

    // PTW payload: latched walk in ISSUE, pass-through replay in WAIT_RESP, zero for LSU.
    always_comb begin
        pipe_req_id_o    = '0;
        pipe_req_paddr_o = '0;
        if (pipe_req_is_ptw_o) begin
            if (state_q == ISSUE) begin
                pipe_req_id_o    = req_buf_q.id;
                pipe_req_paddr_o = req_buf_q.paddr;
            end else begin
                pipe_req_id_o    = replay_req_id_i;
                pipe_req_paddr_o = replay_req_paddr_i;
            end
        end
    end

    // Walk FSM next state, request latch, replay counter and sticky overflow.
    always_comb begin
        state_d      = state_q;
        req_buf_d    = req_buf_q;
        replay_cnt_d = replay_cnt_q;
        ovf_d        = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (ptw_walk_req_vld_i) begin
                    req_buf_d.id    = ptw_walk_req_id_i;
                    req_buf_d.paddr = ptw_walk_req_addr_i;
                    replay_cnt_d    = '0;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (ptw_hsk) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (resp_hsk) begin
                    state_d = IDLE;
                end else if (ptw_hsk) begin
                    if (replay_cnt_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end
                    if (replay_cnt_q != '1) begin
                        replay_cnt_d = replay_cnt_q + PTW_REPLAY_CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            replay_cnt_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            replay_cnt_q <= replay_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    // Walk id/address latch; contents are only meaningful outside IDLE.
    always_ff @(posedge clk) begin
        req_buf_q <= req_buf_d;
    end

`ifndef SYNTHESIS
    a_replay_in_wait: assert property (@(posedge clk) disable iff (rst)
        replay_req_vld_i |-> (state_q == WAIT_RESP));

    a_resp_in_wait: assert property (@(posedge clk) disable iff (rst)
        (ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i) |-> (state_q == WAIT_RESP));

    a_issue_stable: assert property (@(posedge clk) disable iff (rst)
        ((state_q == ISSUE) && pipe_req_is_ptw_o && !pipe_req_rdy_i) |=>
        (pipe_req_vld_o && (!pipe_req_is_ptw_o ||
            ($stable(pipe_req_id_o) && $stable(pipe_req_paddr_o)))));
`endif

endmodule

// File: tb/tb_rvh_l1d_ptw_req_sched.sv
// Scoreboard bench: expected pipe beats are queued by the stimulus thread and
// checked by a monitor on every pipe handshake; status outputs are checked inline.
module tb_rvh_l1d_ptw_req_sched;
    import rvh_l1d_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ptw_walk_req_vld_i = 1'b0;
    logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i = '0;
    logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i = '0;
    logic                    ptw_walk_req_rdy_o;
    logic                    replay_req_vld_i = 1'b0;
    logic [PTW_ID_WIDTH-1:0] replay_req_id_i = '0;
    logic [PADDR_WIDTH-1:0]  replay_req_paddr_i = '0;
    logic                    replay_req_rdy_o;
    logic                    lsu_ld_req_vld_i = 1'b0;
    logic                    lsu_ld_req_rdy_o;
    logic                    pipe_req_vld_o;
    logic                    pipe_req_is_ptw_o;
    logic [PTW_ID_WIDTH-1:0] pipe_req_id_o;
    logic [PADDR_WIDTH-1:0]  pipe_req_paddr_o;
    logic                    pipe_req_rdy_i = 1'b0;
    logic                    ptw_walk_resp_vld_i = 1'b0;
    logic                    ptw_walk_resp_rdy_i = 1'b0;
    logic                    busy_o;
    logic                    replay_overflow_o;

    rvh_l1d_ptw_req_sched #(
        .STARVE_LIMIT(8),
        .MAX_REPLAY  (15)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ptw_walk_req_vld_i  (ptw_walk_req_vld_i),
        .ptw_walk_req_id_i   (ptw_walk_req_id_i),
        .ptw_walk_req_addr_i (ptw_walk_req_addr_i),
        .ptw_walk_req_rdy_o  (ptw_walk_req_rdy_o),
        .replay_req_vld_i    (replay_req_vld_i),
        .replay_req_id_i     (replay_req_id_i),
        .replay_req_paddr_i  (replay_req_paddr_i),
        .replay_req_rdy_o    (replay_req_rdy_o),
        .lsu_ld_req_vld_i    (lsu_ld_req_vld_i),
        .lsu_ld_req_rdy_o    (lsu_ld_req_rdy_o),
        .pipe_req_vld_o      (pipe_req_vld_o),
        .pipe_req_is_ptw_o   (pipe_req_is_ptw_o),
        .pipe_req_id_o       (pipe_req_id_o),
        .pipe_req_paddr_o    (pipe_req_paddr_o),
        .pipe_req_rdy_i      (pipe_req_rdy_i),
        .ptw_walk_resp_vld_i (ptw_walk_resp_vld_i),
        .ptw_walk_resp_rdy_i (ptw_walk_resp_rdy_i),
        .busy_o              (busy_o),
        .replay_overflow_o   (replay_overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                    is_ptw;
        logic [PTW_ID_WIDTH-1:0] id;
        logic [PADDR_WIDTH-1:0]  paddr;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic push(input logic is_ptw, input logic [PTW_ID_WIDTH-1:0] id,
                        input logic [PADDR_WIDTH-1:0] paddr);
        beat_t b;
        b.is_ptw = is_ptw;
        b.id     = id;
        b.paddr  = paddr;
        sb.push_back(b);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pipe beat must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && pipe_req_vld_o && pipe_req_rdy_i) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got is_ptw=%0b id=%0h paddr=%0h expected no beat at %0t",
                         pipe_req_is_ptw_o, pipe_req_id_o, pipe_req_paddr_o, $time);
            end else begin
                e = sb.pop_front();
                if (pipe_req_is_ptw_o !== e.is_ptw || pipe_req_id_o !== e.id ||
                    pipe_req_paddr_o !== e.paddr) begin
                    n_err++;
                    $display("FAIL sb_beat: got is_ptw=%0b id=%0h paddr=%0h expected is_ptw=%0b id=%0h paddr=%0h at %0t",
                             pipe_req_is_ptw_o, pipe_req_id_o, pipe_req_paddr_o,
                             e.is_ptw, e.id, e.paddr, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PADDR_WIDTH-1:0] a;

        // Reset values
        #2;
        chk("rst_walk_rdy", ptw_walk_req_rdy_o, 1);
        chk("rst_pipe_vld", pipe_req_vld_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", replay_overflow_o, 0);
        chk("rst_replay_rdy", replay_req_rdy_o, 0);
        chk("rst_lsu_rdy", lsu_ld_req_rdy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic walk id=3
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = 4'd3;
        ptw_walk_req_addr_i = 56'h8000_1000;
        pipe_req_rdy_i      = 1'b1;
        #1;
        chk("c0_walk_rdy", ptw_walk_req_rdy_o, 1);
        chk("c0_busy", busy_o, 0);
        step();
        ptw_walk_req_vld_i = 1'b0;
        push(1'b1, 4'd3, 56'h8000_1000);
        #1;
        chk("c1_pipe_vld", pipe_req_vld_o, 1);
        chk("c1_is_ptw", pipe_req_is_ptw_o, 1);
        chk("c1_busy", busy_o, 1);
        chk("c1_walk_rdy", ptw_walk_req_rdy_o, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wait_busy", busy_o, 1);
            chk("wait_pipe_vld", pipe_req_vld_o, 0);
            step();
        end
        ptw_walk_resp_vld_i = 1'b1;
        ptw_walk_resp_rdy_i = 1'b1;
        step();
        ptw_walk_resp_vld_i = 1'b0;
        ptw_walk_resp_rdy_i = 1'b0;
        #1;
        chk("c6_busy", busy_o, 0);
        chk("c6_walk_rdy", ptw_walk_req_rdy_o, 1);

        // Replay while outstanding, then replay colliding with response
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = 4'd5;
        ptw_walk_req_addr_i = 56'h8000_2000;
        step();
        ptw_walk_req_vld_i = 1'b0;
        push(1'b1, 4'd5, 56'h8000_2000);
        step();
        replay_req_vld_i   = 1'b1;
        replay_req_id_i    = 4'd5;
        replay_req_paddr_i = 56'h8000_1000;
        push(1'b1, 4'd5, 56'h8000_1000);
        #1;
        chk("rp_rdy", replay_req_rdy_o, 1);
        chk("rp_is_ptw", pipe_req_is_ptw_o, 1);
        step();
        replay_req_paddr_i  = 56'h8000_1008;
        ptw_walk_resp_vld_i = 1'b1;
        ptw_walk_resp_rdy_i = 1'b1;
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = 4'd7;
        ptw_walk_req_addr_i = 56'h8000_3000;
        #1;
        chk("rp_resp_rdy", replay_req_rdy_o, 0);
        chk("rp_resp_pipe_vld", pipe_req_vld_o, 0);
        chk("rp_resp_walk_rdy", ptw_walk_req_rdy_o, 0);
        step();
        replay_req_vld_i    = 1'b0;
        ptw_walk_resp_vld_i = 1'b0;
        ptw_walk_resp_rdy_i = 1'b0;
        #1;
        chk("after_resp_busy", busy_o, 0);
        chk("after_resp_walk_rdy", ptw_walk_req_rdy_o, 1);
        step();

        // LSU contention: ISSUE wins, then LSU, then force grant after 8 lost cycles
        ptw_walk_req_vld_i = 1'b0;
        lsu_ld_req_vld_i   = 1'b1;
        push(1'b1, 4'd7, 56'h8000_3000);
        #1;
        chk("lsu_issue_is_ptw", pipe_req_is_ptw_o, 1);
        chk("lsu_issue_lsu_rdy", lsu_ld_req_rdy_o, 0);
        step();
        push(1'b0, '0, '0);
        #1;
        chk("lsu_gnt_rdy", lsu_ld_req_rdy_o, 1);
        chk("lsu_gnt_is_ptw", pipe_req_is_ptw_o, 0);
        step();
        replay_req_vld_i = 1'b1;
        replay_req_id_i  = 4'd7;
        for (int i = 0; i < 8; i++) begin
            a = 56'h8000_3000 + 56'(i * 8);
            replay_req_paddr_i = a;
            push(1'b1, 4'd7, a);
            #1;
            chk("starve_lsu_rdy", lsu_ld_req_rdy_o, 0);
            chk("starve_replay_rdy", replay_req_rdy_o, 1);
            step();
        end
        replay_req_paddr_i = 56'h8000_3040;
        push(1'b0, '0, '0);
        #1;
        chk("force_lsu_rdy", lsu_ld_req_rdy_o, 1);
        chk("force_replay_rdy", replay_req_rdy_o, 0);
        chk("force_is_ptw", pipe_req_is_ptw_o, 0);
        chk("force_id_zero", pipe_req_id_o, 0);
        step();
        lsu_ld_req_vld_i    = 1'b0;
        replay_req_vld_i    = 1'b0;
        ptw_walk_resp_vld_i = 1'b1;
        ptw_walk_resp_rdy_i = 1'b1;
        step();
        ptw_walk_resp_vld_i = 1'b0;
        ptw_walk_resp_rdy_i = 1'b0;
        #1;
        chk("lsu_end_busy", busy_o, 0);
        chk("lsu_end_ovf", replay_overflow_o, 0);

        // Back-pressure: ISSUE held for 20 cycles
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = 4'd9;
        ptw_walk_req_addr_i = 56'h8000_4000;
        pipe_req_rdy_i      = 1'b0;
        step();
        ptw_walk_req_vld_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hold_vld_ptw", {pipe_req_vld_o, pipe_req_is_ptw_o, busy_o}, 3'b111);
            chk("hold_id", pipe_req_id_o, 9);
            chk("hold_paddr", pipe_req_paddr_o, 56'h8000_4000);
            step();
        end
        pipe_req_rdy_i = 1'b1;
        push(1'b1, 4'd9, 56'h8000_4000);
        step();

        // 16 replays in one walk: overflow after the 16th
        replay_req_vld_i = 1'b1;
        replay_req_id_i  = 4'd9;
        for (int i = 0; i < 16; i++) begin
            a = 56'h8000_5000 + 56'(i * 64);
            replay_req_paddr_i = a;
            push(1'b1, 4'd9, a);
            #1;
            chk("ovf_replay_rdy", replay_req_rdy_o, 1);
            step();
            chk("ovf_flag", replay_overflow_o, (i == 15) ? 1 : 0);
        end
        replay_req_vld_i    = 1'b0;
        ptw_walk_resp_vld_i = 1'b1;
        ptw_walk_resp_rdy_i = 1'b1;
        step();
        ptw_walk_resp_vld_i = 1'b0;
        ptw_walk_resp_rdy_i = 1'b0;
        #1;
        chk("ovf_sticky_idle", replay_overflow_o, 1);
        chk("ovf_idle_busy", busy_o, 0);
        step();
        chk("ovf_sticky_later", replay_overflow_o, 1);

        // Async reset in WAIT_RESP during a replay
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = 4'd2;
        ptw_walk_req_addr_i = 56'h8000_6000;
        step();
        ptw_walk_req_vld_i = 1'b0;
        push(1'b1, 4'd2, 56'h8000_6000);
        step();
        replay_req_vld_i   = 1'b1;
        replay_req_id_i    = 4'd2;
        replay_req_paddr_i = 56'h8000_6040;
        push(1'b1, 4'd2, 56'h8000_6040);
        #1;
        chk("pre_rst_replay_rdy", replay_req_rdy_o, 1);
        step();
        replay_req_paddr_i = 56'h8000_6080;
        rst = 1'b1;
        #1;
        chk("arst_walk_rdy", ptw_walk_req_rdy_o, 1);
        chk("arst_pipe_vld", pipe_req_vld_o, 0);
        chk("arst_is_ptw", pipe_req_is_ptw_o, 0);
        chk("arst_replay_rdy", replay_req_rdy_o, 0);
        chk("arst_lsu_rdy", lsu_ld_req_rdy_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ovf", replay_overflow_o, 0);
        chk("arst_paddr", pipe_req_paddr_o, 0);
        replay_req_vld_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
